// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: opcodes, response bytes,
// state encoding and a counter-width helper.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_NAK = 8'h4E;
  localparam logic [7:0] RSP_TMO = 8'h54;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_GET_DATA  = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  localparam logic [2:0] ST_RESPOND   = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    GET_ADDR  = ST_GET_ADDR,
    GET_DATA  = ST_GET_DATA,
    ISSUE     = ST_ISSUE,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP,
    RESPOND   = ST_RESPOND
  } state_t;

  // Counter width for a terminal count of lim-1, never narrower than 1 bit.
  function automatic int cnt_w(input int lim);
    return (lim > 1) ? $clog2(lim) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle of RX byte stream, AXI-lite master command port and TX response
// port seen by the parser. master = parser side, slave = surrounding logic.
interface uart_cmd_parser_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [7:0] DATA;
  logic [3:0] ADDR;
  logic       DIR;
  logic       INIT_TXN;
  logic       TXN_DONE;
  logic       ERROR;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       TX_BUSY;
  logic       BUSY;
  logic       OVERRUN;

  modport master (
    input  RX_DATA, RX_VALID, TXN_DONE, ERROR, TX_BUSY,
    output DATA, ADDR, DIR, INIT_TXN, TX_DATA, TX_START, BUSY, OVERRUN
  );

  modport slave (
    output RX_DATA, RX_VALID, TXN_DONE, ERROR, TX_BUSY,
    input  DATA, ADDR, DIR, INIT_TXN, TX_DATA, TX_START, BUSY, OVERRUN
  );
endinterface

// File: rtl/uart_cmd_parser_cmd_timeout.sv
// Saturating cycle counter; expired is high once LIMIT-1 cycles of enable
// have elapsed since the last clear, and stays high until cleared.
module cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = cnt_w(LIMIT);
  localparam logic [W-1:0] TERM = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Count while enabled, hold at the terminal value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clear)                  cnt <= '0;
    else if (enable && cnt != TERM)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == TERM);
endmodule

// File: rtl/uart_cmd_parser.sv
// Parses 'W' addr data / 'R' addr frames from the UART RX byte stream,
// drives one AXI-lite master transaction per good frame and queues a
// single status byte for the UART TX.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int TXN_TIMEOUT  = 1024
) (
  input  logic               M_AXI_ACLK,
  input  logic               M_AXI_ARESETN,
  uart_cmd_parser_if.master  bus
);
  state_t     state, state_nx;
  logic       dir_r;
  logic [7:0] resp;
  logic       gap_cnt;
  logic       byte_exp, txn_exp;
  logic       in_frame, busy_st;

  // next-state control strobes
  logic       ld_dir, dir_nx, ld_addr, ld_data, set_init, clr_init;
  logic       ld_resp, tx_go;
  logic [7:0] resp_nx;

  assign in_frame = (state == GET_ADDR) || (state == GET_DATA);
  assign busy_st  = !((state == IDLE) || in_frame);
  assign bus.BUSY = busy_st;
  assign bus.DIR  = dir_r;

  // Inter-byte timer: runs only while collecting frame bytes, restarts on each byte.
  cmd_timeout #(.LIMIT(BYTE_TIMEOUT)) u_byte_tmo (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear   (!in_frame || bus.RX_VALID),
    .enable  (in_frame),
    .expired (byte_exp)
  );

  // Transaction timer: counts from WAIT_DONE entry.
  cmd_timeout #(.LIMIT(TXN_TIMEOUT)) u_txn_tmo (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear   (state != WAIT_DONE),
    .enable  (state == WAIT_DONE),
    .expired (txn_exp)
  );

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nx;
  end

  // Next-state and datapath strobes; a received byte always beats a timeout.
  always_comb begin
    state_nx = state;
    ld_dir   = 1'b0;
    dir_nx   = 1'b0;
    ld_addr  = 1'b0;
    ld_data  = 1'b0;
    set_init = 1'b0;
    clr_init = 1'b0;
    ld_resp  = 1'b0;
    resp_nx  = RSP_OK;
    tx_go    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.RX_VALID) begin
          if (bus.RX_DATA == OP_WRITE) begin
            ld_dir = 1'b1; dir_nx = 1'b1; state_nx = GET_ADDR;
          end else if (bus.RX_DATA == OP_READ) begin
            ld_dir = 1'b1; dir_nx = 1'b0; state_nx = GET_ADDR;
          end else begin
            ld_resp = 1'b1; resp_nx = RSP_NAK; state_nx = RESPOND;
          end
        end
      end
      GET_ADDR: begin
        if (bus.RX_VALID) begin
          // register map is 4 word-aligned slots: 0x0,0x4,0x8,0xC
          if (bus.RX_DATA[7:4] == 4'h0 && bus.RX_DATA[1:0] == 2'b00) begin
            ld_addr  = 1'b1;
            state_nx = dir_r ? GET_DATA : ISSUE;
          end else begin
            ld_resp = 1'b1; resp_nx = RSP_NAK; state_nx = RESPOND;
          end
        end else if (byte_exp) begin
          ld_resp = 1'b1; resp_nx = RSP_TMO; state_nx = RESPOND;
        end
      end
      GET_DATA: begin
        if (bus.RX_VALID) begin
          ld_data = 1'b1; state_nx = ISSUE;
        end else if (byte_exp) begin
          ld_resp = 1'b1; resp_nx = RSP_TMO; state_nx = RESPOND;
        end
      end
      ISSUE: begin
        set_init = 1'b1;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.TXN_DONE) begin
          clr_init = 1'b1; ld_resp = 1'b1;
          resp_nx  = bus.ERROR ? RSP_ERR : RSP_OK;
          state_nx = GAP;
        end else if (txn_exp) begin
          clr_init = 1'b1; ld_resp = 1'b1; resp_nx = RSP_TMO;
          state_nx = GAP;
        end
      end
      GAP: begin
        // two low cycles so the master's edge detector re-arms
        if (gap_cnt) state_nx = RESPOND;
      end
      RESPOND: begin
        if (!bus.TX_BUSY) begin
          tx_go = 1'b1; state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command/response registers; TX_START and OVERRUN are single-cycle pulses.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      dir_r        <= 1'b0;
      bus.ADDR     <= '0;
      bus.DATA     <= '0;
      bus.INIT_TXN <= 1'b0;
      resp         <= '0;
      bus.TX_DATA  <= '0;
      bus.TX_START <= 1'b0;
      bus.OVERRUN  <= 1'b0;
      gap_cnt      <= 1'b0;
    end else begin
      if (ld_dir)   dir_r    <= dir_nx;
      if (ld_addr)  bus.ADDR <= bus.RX_DATA[3:0];
      if (ld_data)  bus.DATA <= bus.RX_DATA;
      if (set_init)      bus.INIT_TXN <= 1'b1;
      else if (clr_init) bus.INIT_TXN <= 1'b0;
      if (ld_resp)  resp <= resp_nx;
      if (tx_go)    bus.TX_DATA <= resp;
      bus.TX_START <= tx_go;
      bus.OVERRUN  <= bus.RX_VALID && busy_st;
      gap_cnt      <= (state == GAP) && (state_nx == GAP);
    end
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Upstream stage of the UART-to-AXI-lite bridge. Takes received UART bytes and parses fixed-length command frames.
- Drives the AXI-lite master's command interface: DATA, ADDR, DIR, INIT_TXN. Waits for TXN_DONE.
- Queues a one-byte status response to the UART transmitter.
- Frames: 'W'(0x57) addr data = write; 'R'(0x52) addr = read. Responses: 'K'(0x4B) ok, 'E'(0x45) bus error, 'N'(0x4E) bad frame, 'T'(0x54) timeout.

Parameters:
BYTE_TIMEOUT, 100000, max clock cycles between bytes inside one frame.
TXN_TIMEOUT, 1024, max clock cycles from INIT_TXN rise to TXN_DONE.

Ports:
M_AXI_ACLK  in  1  clock.
M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
RX_DATA  in  8  received byte; valid only while RX_VALID is high.
RX_VALID  in  1  one-cycle strobe, one per received byte.
DATA  out  8  write data to the master.
ADDR  out  4  register address to the master.
DIR  out  1  1 = write, 0 = read.
INIT_TXN  out  1  transaction request level; the master detects its rising edge.
TXN_DONE  in  1  one-cycle completion pulse from the master.
ERROR  in  1  master error flag; sampled in the same cycle as TXN_DONE.
TX_DATA  out  8  response byte.
TX_START  out  1  one-cycle strobe to the UART transmitter.
TX_BUSY  in  1  transmitter busy.
BUSY  out  1  high in every state except IDLE, GET_ADDR and GET_DATA.
OVERRUN  out  1  one-cycle pulse when an RX byte is dropped.

Behaviour:
- Reset (async, ARESETN=0): all outputs 0, state IDLE, counters 0. Reset mid-transaction drops INIT_TXN immediately. No response is sent for the aborted frame.
- States: IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT_DONE, GAP, RESPOND.
- IDLE:
  - On RX_VALID with 0x57: DIR_r<=1, go to GET_ADDR.
  - On RX_VALID with 0x52: DIR_r<=0, go to GET_ADDR.
  - Any other byte: resp<='N', go to RESPOND.
- GET_ADDR: on RX_VALID, check RX_DATA[7:4]==0 and RX_DATA[1:0]==0.
  - Check fails: resp<='N', go to RESPOND.
  - Check passes: ADDR<=RX_DATA[3:0], then go to GET_DATA if write, else ISSUE.
- GET_DATA: on RX_VALID, DATA<=RX_DATA, go to ISSUE.
- Inter-byte timer:
  - Clears on every accepted byte and on entering GET_ADDR.
  - Increments each cycle while in GET_ADDR or GET_DATA.
  - Reaching BYTE_TIMEOUT-1 with no byte: resp<='T', go to RESPOND. ADDR and DATA keep their old values.
  - If a byte arrives in the same cycle as expiry, the byte wins.
- ISSUE: INIT_TXN<=1; DIR, ADDR and DATA are already stable at this point and stay stable until INIT_TXN falls. Go to WAIT_DONE next cycle.
- WAIT_DONE:
  - Transaction timer counts from entry.
  - TXN_DONE=1: INIT_TXN<=0, resp<=(ERROR?'E':'K'), go to GAP.
  - Timer reaches TXN_TIMEOUT-1 with no TXN_DONE: INIT_TXN<=0, resp<='T', go to GAP.
  - TXN_DONE wins if it coincides with timeout.
- GAP: holds INIT_TXN low for exactly 2 cycles, so the master's 2-flop edge detector sees a low level before any new rise. Then go to RESPOND.
- RESPOND:
  - Wait while TX_BUSY=1.
  - When TX_BUSY=0: TX_DATA<=resp, TX_START=1 for exactly one cycle, go to IDLE.
  - TX_DATA holds its value until the next response.
- Latency: frame-complete byte to INIT_TXN high is 1 cycle (ISSUE registered) plus 1 cycle.
- Dropped bytes:
  - RX_VALID in ISSUE, WAIT_DONE, GAP or RESPOND: byte dropped, OVERRUN pulses one cycle, state unaffected.
  - A byte arriving in IDLE in the same cycle as the RESPOND->IDLE transition is dropped; the transition happens on that edge, so RESPOND is still the active state.
- Counter widths: $clog2 of the respective parameter, minimum 1. No wrap: each counter saturates at its terminal value until the state changes.

Decomposition:
- Package uart_cmd_pkg holds:
  - Opcode constants OP_WRITE=8'h57, OP_READ=8'h52.
  - Response constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_NAK=8'h4E, RSP_TMO=8'h54.
  - State encoding localparams, 3 bits.
- One sub-module, cmd_timeout, parameterised by LIMIT, with ports clear and enable and output expired. It is instantiated twice: once for the byte timer, once for the transaction timer.

Test Plan:
- Write: RX 0x57,0x08,0xA5 with TXN_DONE pulsed 5 cycles after INIT_TXN rises, ERROR=0 -> DIR=1, ADDR=4'h8, DATA=8'hA5 while INIT_TXN=1; INIT_TXN falls the cycle after TXN_DONE; TX_START pulses once with TX_DATA=0x4B.
- Read with error: RX 0x52,0x0C, then TXN_DONE with ERROR=1 -> DIR=0, ADDR=4'hC; no DATA change; TX_DATA=0x45.
- Bad frames -> TX_DATA=0x4E and INIT_TXN never rises:
  - RX 0x41.
  - RX 0x57,0x05 (misaligned).
  - RX 0x57,0x10 (upper nibble set).
- Timeouts (BYTE_TIMEOUT=16, TXN_TIMEOUT=8):
  - RX 0x57,0x04 then silence -> TX_DATA=0x54 16 cycles after the last byte.
  - Read with no TXN_DONE -> INIT_TXN low after 8 cycles, then TX_DATA=0x54.
- Overrun/back-pressure: RX byte during WAIT_DONE -> OVERRUN pulse, frame completes normally. TX_BUSY=1 for 20 cycles in RESPOND -> TX_START is delayed until TX_BUSY falls and pulses exactly once.
- Async reset asserted in WAIT_DONE with INIT_TXN=1 -> INIT_TXN=0 and BUSY=0 before the next clock edge; no TX_START after release.
